// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the reference-domain command scheduler:
// frame command codes, the fixed ALU operand registers and the FSM states.
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int OPA_ADDR = 0;
  localparam int OPB_ADDR = 1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_TX_RD,
    ST_OP_A,
    ST_OP_B,
    ST_ALU_FN,
    ST_ALU_WAIT,
    ST_TX_LO,
    ST_TX_HI
  } state_t;

endpackage

// File: rtl/tx_byte_pusher.sv
// Registered TX FIFO push: a requested byte is pushed only when the FIFO
// is not full; otherwise the request (and its byte) is simply held upstream.
module tx_byte_pusher #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  i_req,
  input  logic [DATA_WIDTH-1:0] i_byte,
  input  logic                  i_full,
  output logic                  o_fire,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  output logic                  o_wr_inc
);

  assign o_fire = i_req & ~i_full;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      o_wr_data <= '0;
      o_wr_inc  <= 1'b0;
    end else begin
      o_wr_inc <= o_fire;
      if (o_fire) o_wr_data <= i_byte;
    end
  end

endmodule

// File: rtl/sys_ctrl_sched.sv
// Command scheduler: decodes framed RX commands, sequences RF/ALU access and
// streams response bytes to the TX FIFO. Every output is a flop.
module sys_ctrl_sched
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 4,
  parameter int ALU_FN_WIDTH = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   rx_data,
  input  logic                    rx_valid,
  output logic [ADDR_WIDTH-1:0]   rf_addr,
  output logic [DATA_WIDTH-1:0]   rf_wr_data,
  output logic                    rf_wr_en,
  output logic                    rf_rd_en,
  input  logic [DATA_WIDTH-1:0]   rf_rd_data,
  input  logic                    rf_rd_valid,
  output logic [ALU_FN_WIDTH-1:0] alu_fn,
  output logic                    alu_en,
  input  logic [2*DATA_WIDTH-1:0] alu_out,
  input  logic                    alu_out_valid,
  output logic                    clk_gate_en,
  output logic [DATA_WIDTH-1:0]   fifo_wr_data,
  output logic                    fifo_wr_inc,
  input  logic                    fifo_full
);

  state_t                  r_state, w_next;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_rd_byte;
  logic [2*DATA_WIDTH-1:0] r_alu_res;

  logic [ADDR_WIDTH-1:0]   w_rf_addr;
  logic [DATA_WIDTH-1:0]   w_rf_wr_data;
  logic                    w_rf_wr_en, w_rf_rd_en;
  logic [ALU_FN_WIDTH-1:0] w_alu_fn;
  logic                    w_alu_en, w_clk_gate;
  logic                    w_tx_req, w_fire;
  logic [DATA_WIDTH-1:0]   w_tx_byte;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (rx_valid) begin
        case (rx_data)
          CMD_RF_WR:   w_next = ST_WR_ADDR;
          CMD_RF_RD:   w_next = ST_RD_ADDR;
          CMD_ALU_OP:  w_next = ST_OP_A;
          CMD_ALU_NOP: w_next = ST_ALU_FN;
          default:     w_next = ST_IDLE;
        endcase
      end
      ST_WR_ADDR:  if (rx_valid)      w_next = ST_WR_DATA;
      ST_WR_DATA:  if (rx_valid)      w_next = ST_IDLE;
      ST_RD_ADDR:  if (rx_valid)      w_next = ST_RD_WAIT;
      ST_RD_WAIT:  if (rf_rd_valid)   w_next = ST_TX_RD;
      ST_TX_RD:    if (w_fire)        w_next = ST_IDLE;
      ST_OP_A:     if (rx_valid)      w_next = ST_OP_B;
      ST_OP_B:     if (rx_valid)      w_next = ST_ALU_FN;
      ST_ALU_FN:   if (rx_valid)      w_next = ST_ALU_WAIT;
      ST_ALU_WAIT: if (alu_out_valid) w_next = ST_TX_LO;
      ST_TX_LO:    if (w_fire)        w_next = ST_TX_HI;
      ST_TX_HI:    if (w_fire)        w_next = ST_IDLE;
      default:                        w_next = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; data buses hold, strobes default low.
  always_comb begin
    w_rf_addr    = rf_addr;
    w_rf_wr_data = rf_wr_data;
    w_rf_wr_en   = 1'b0;
    w_rf_rd_en   = 1'b0;
    w_alu_fn     = alu_fn;
    w_alu_en     = 1'b0;
    w_clk_gate   = (w_next == ST_ALU_FN) || (w_next == ST_ALU_WAIT);
    if (rx_valid) begin
      case (r_state)
        ST_WR_DATA: begin
          w_rf_addr    = r_addr;
          w_rf_wr_data = rx_data;
          w_rf_wr_en   = 1'b1;
        end
        ST_RD_ADDR: begin
          w_rf_addr  = rx_data[ADDR_WIDTH-1:0];
          w_rf_rd_en = 1'b1;
        end
        ST_OP_A: begin
          w_rf_addr    = ADDR_WIDTH'(OPA_ADDR);
          w_rf_wr_data = rx_data;
          w_rf_wr_en   = 1'b1;
        end
        ST_OP_B: begin
          w_rf_addr    = ADDR_WIDTH'(OPB_ADDR);
          w_rf_wr_data = rx_data;
          w_rf_wr_en   = 1'b1;
        end
        ST_ALU_FN: begin
          w_alu_fn = rx_data[ALU_FN_WIDTH-1:0];
          w_alu_en = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rf_addr     <= '0;
      rf_wr_data  <= '0;
      rf_wr_en    <= 1'b0;
      rf_rd_en    <= 1'b0;
      alu_fn      <= '0;
      alu_en      <= 1'b0;
      clk_gate_en <= 1'b0;
      r_addr      <= '0;
      r_rd_byte   <= '0;
      r_alu_res   <= '0;
    end else begin
      rf_addr     <= w_rf_addr;
      rf_wr_data  <= w_rf_wr_data;
      rf_wr_en    <= w_rf_wr_en;
      rf_rd_en    <= w_rf_rd_en;
      alu_fn      <= w_alu_fn;
      alu_en      <= w_alu_en;
      clk_gate_en <= w_clk_gate;
      if (r_state == ST_WR_ADDR && rx_valid)     r_addr    <= rx_data[ADDR_WIDTH-1:0];
      if (r_state == ST_RD_WAIT && rf_rd_valid)  r_rd_byte <= rf_rd_data;
      if (r_state == ST_ALU_WAIT && alu_out_valid) r_alu_res <= alu_out;
    end
  end

  assign w_tx_req = (r_state == ST_TX_RD) || (r_state == ST_TX_LO) || (r_state == ST_TX_HI);

  always_comb begin
    case (r_state)
      ST_TX_RD: w_tx_byte = r_rd_byte;
      ST_TX_LO: w_tx_byte = r_alu_res[DATA_WIDTH-1:0];
      default:  w_tx_byte = r_alu_res[2*DATA_WIDTH-1:DATA_WIDTH];
    endcase
  end

  tx_byte_pusher #(.DATA_WIDTH(DATA_WIDTH)) u_pusher (
    .CLK       (CLK),
    .RST       (RST),
    .i_req     (w_tx_req),
    .i_byte    (w_tx_byte),
    .i_full    (fifo_full),
    .o_fire    (w_fire),
    .o_wr_data (fifo_wr_data),
    .o_wr_inc  (fifo_wr_inc)
  );

endmodule
